// File: rtl/servo_angle_sequencer.sv
// Servo angle sequencer: conditions the board buttons and the sweep switch, then steps the
// 3-bit angle code either by hand (up/down) or by an automatic bouncing sweep.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_OFF    | servo idle, degree forced to 0, waits for a center press
// ST_MANUAL | up/down presses step degree within 1..7
// ST_SWEEP  | degree bounces 1..7..1, one step per dwell period

module servo_angle_sequencer #(
   parameter int DEBOUNCE_CYCLES = 200000,
   parameter int DWELL_CYCLES    = 5000000
) (
   input  logic       clk_10MHz,
   input  logic       reset,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic       btn_center,
   input  logic       sw_sweep,
   output logic [2:0] degree,
   output logic [1:0] mode,
   output logic       sweep_dir
);

   localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
   localparam int DW_W = $clog2(DWELL_CYCLES);
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [DW_W-1:0] DW_LAST = DW_W'(DWELL_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_OFF    = 2'd0,
      ST_MANUAL = 2'd1,
      ST_SWEEP  = 2'd2
   } state_t;

   // bit order everywhere below: {sw_sweep, btn_center, btn_down, btn_up}
   logic [3:0]      raw_d;
   logic [3:0]      sync1_q;
   logic [3:0]      sync2_q;
   logic [3:0]      level_q;
   logic [3:0]      level_dly_q;
   logic [2:0]      press_q;
   logic [DB_W-1:0] db_cnt_q [4];

   state_t          state_q;
   logic [2:0]      degree_q;
   logic            dir_q;
   logic [DW_W-1:0] dwell_q;

   logic            up_p;
   logic            down_p;
   logic            center_p;
   logic            sweep_lvl;

   assign raw_d = {sw_sweep, btn_center, btn_down, btn_up};

   always_ff @(posedge clk_10MHz) begin
      if (!reset) begin
         sync1_q     <= '0;
         sync2_q     <= '0;
         level_q     <= '0;
         level_dly_q <= '0;
         press_q     <= '0;
         for (int i = 0; i < 4; i++) begin
            db_cnt_q[i] <= '0;
         end
      end else begin
         sync1_q     <= raw_d;
         sync2_q     <= sync1_q;
         level_dly_q <= level_q;
         press_q     <= level_q[2:0] & ~level_dly_q[2:0];
         for (int i = 0; i < 4; i++) begin
            if (sync2_q[i] == level_q[i]) begin
               db_cnt_q[i] <= '0;
            end else if (db_cnt_q[i] == DB_LAST) begin
               level_q[i]  <= sync2_q[i];
               db_cnt_q[i] <= '0;
            end else begin
               db_cnt_q[i] <= db_cnt_q[i] + DB_W'(1);
            end
         end
      end
   end

   // The switch is taken from the delayed level so it reaches the FSM on the same cycle
   // a button press would, keeping input-to-output latency identical for all inputs.
   assign up_p      = press_q[0];
   assign down_p    = press_q[1];
   assign center_p  = press_q[2];
   assign sweep_lvl = level_dly_q[3];

   always_ff @(posedge clk_10MHz) begin
      if (!reset) begin
         state_q  <= ST_OFF;
         degree_q <= 3'd0;
         dir_q    <= 1'b1;
         dwell_q  <= '0;
      end else begin
         case (state_q)
            ST_OFF: begin
               degree_q <= 3'd0;
               dwell_q  <= '0;
               if (center_p) begin
                  state_q  <= ST_MANUAL;
                  degree_q <= 3'd1;
               end
            end
            ST_MANUAL: begin
               dwell_q <= '0;
               if (center_p) begin
                  state_q  <= ST_OFF;
                  degree_q <= 3'd0;
               end else if (sweep_lvl) begin
                  state_q <= ST_SWEEP;
                  dir_q   <= (degree_q != 3'd7);
               end else if (up_p && !down_p && degree_q != 3'd7) begin
                  degree_q <= degree_q + 3'd1;
               end else if (down_p && !up_p && degree_q > 3'd1) begin
                  degree_q <= degree_q - 3'd1;
               end
            end
            ST_SWEEP: begin
               if (center_p) begin
                  state_q  <= ST_OFF;
                  degree_q <= 3'd0;
                  dwell_q  <= '0;
               end else if (!sweep_lvl) begin
                  state_q <= ST_MANUAL;
                  dwell_q <= '0;
               end else if (dwell_q == DW_LAST) begin
                  dwell_q <= '0;
                  if (dir_q) begin
                     degree_q <= degree_q + 3'd1;
                     if (degree_q == 3'd6) dir_q <= 1'b0;
                  end else begin
                     degree_q <= degree_q - 3'd1;
                     if (degree_q == 3'd2) dir_q <= 1'b1;
                  end
               end else begin
                  dwell_q <= dwell_q + DW_W'(1);
               end
            end
            default: begin
               state_q  <= ST_OFF;
               degree_q <= 3'd0;
               dwell_q  <= '0;
            end
         endcase
      end
   end

   assign degree    = degree_q;
   assign mode      = state_q;
   assign sweep_dir = dir_q;

endmodule
